inst_fetch_unit: RTL



---
 rtl/ifu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/inst_fetch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM state, reset PC default
// and the prefetch FIFO entry layout.
package ifu_pkg;

    // Width of the PC and instruction fields carried by a prefetch entry.
    localparam int unsigned IFU_XLEN = 32;

    // Word index fetched first after reset unless overridden.
    localparam int unsigned IFU_RESET_PC = 0;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StDone = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for prefetched instructions. Push, pop and flush are
// sampled on the rising edge; flush wins over both. Pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents past the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the asynchronous instruction
// memory, prefetches into fetch_fifo and hands instructions to decode over a
// valid/ready handshake. Redirects flush the prefetch queue.
// Optional statistics counters are enabled with the macro IFU_STATS_EN.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    // Entry layout in ifu_pkg fixes the PC/instruction width at IFU_XLEN.
    parameter int unsigned DATA_WIDTH = IFU_XLEN,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned RESET_PC   = IFU_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  fetch_done
`ifdef IFU_STATS_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] MEM_WORDS = DATA_WIDTH'(64'd1 << ADDR_WIDTH);
    localparam logic [DATA_WIDTH-1:0] LAST_PC   = MEM_WORDS - 1'b1;

    ifu_state_e        state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    fetch_entry_t      held_q;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop_req;
    logic              push_req;
    logic              fifo_push;
    logic              fifo_pop;

    // Handshake and priority decode: a redirect suppresses both push and pop.
    always_comb begin
        pop_req         = inst_valid && inst_ready;
        push_req        = (state_q == StRun) &&
                          ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop_req);
        fifo_pop        = pop_req && !redirect_valid;
        fifo_push       = push_req && !redirect_valid;
        push_entry.pc   = pc_q;
        push_entry.inst = imem_data;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // PC and RUN/DONE state; the push of the last word ends fetching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= DATA_WIDTH'(RESET_PC);
            state_q <= StRun;
        end else if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= (redirect_pc >= MEM_WORDS) ? StDone : StRun;
        end else if (fifo_push) begin
            pc_q <= pc_q + 1'b1;
            if (pc_q == LAST_PC) state_q <= StDone;
        end
    end

    // Remember the visible head so outputs hold it once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
        end else if (!fifo_empty) begin
            held_q <= head_entry;
        end
    end

    assign imem_addr  = pc_q;
    assign inst_valid = !fifo_empty;
    assign inst_out   = fifo_empty ? held_q.inst : head_entry.inst;
    assign inst_pc    = fifo_empty ? held_q.pc : head_entry.pc;
    assign fetch_done = (state_q == StDone);

`ifdef IFU_STATS_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;
    logic        stall_cond;

    assign stall_cond = (state_q == StRun) && fifo_full && !pop_req;

    // Saturating push and stall counters, cleared by a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else if (redirect_valid) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (fifo_push && (fetch_count_q != '1)) fetch_count_q <= fetch_count_q + 1'b1;
            if (stall_cond && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
